rbcp_axil_master: RTL
=====================

RBCP_AXIL_MASTER -- requirements
Module: rbcp_axil_master

Sits directly downstream of the SiTCP RBCP port. Turns byte-wide RBCP register accesses into single 32-bit AXI4-Lite master transactions, for example towards AXI GPIO.

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023: maximum number of cycles to wait for an AXI handshake or response.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port rbcp_act, input, 1: RBCP session active; requests are accepted only while it is high.
REQ-005 SHALL have port rbcp_addr, input, 32: byte address.
REQ-006 SHALL have port rbcp_wd, input, 8: write byte.
REQ-007 SHALL have port rbcp_we / rbcp_re, input, 1 each: single-cycle write / read strobes.
REQ-008 SHALL have port rbcp_ack, output, 1: single-cycle completion pulse.
REQ-009 SHALL have port rbcp_rd, output, 8: read byte, valid while rbcp_ack is high.
REQ-010 SHALL have the following AXI4-Lite master ports:
- m_axi_awaddr out 32, m_axi_awvalid out 1, m_axi_awready in 1
- m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1
- m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1
- m_axi_araddr out 32, m_axi_arvalid out 1, m_axi_arready in 1
- m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1
REQ-011 SHALL have ports debug_bresp / debug_rresp, output, 2 each: last write / read response code, or 2'b11 on timeout.

Function
REQ-012 SHALL implement the FSM states IDLE, WR, WR_RESP, RD, RD_RESP, DONE.
REQ-013 IDLE SHALL accept a request when rbcp_act=1 and rbcp_we or rbcp_re is high.
- Accept latches the address and data.
- If we and re are high in the same cycle, the write SHALL win and the read SHALL be dropped.
REQ-014 Address mapping SHALL be awaddr/araddr = {rbcp_addr[31:2],2'b00} and lane = rbcp_addr[1:0].
REQ-015 Write data SHALL be wdata = {4{rbcp_wd}} and wstrb = 4'b0001 << lane.
REQ-016 In WR, awvalid and wvalid SHALL assert the cycle after accept.
- Each valid drops independently once its own ready has been sampled high.
- The FSM moves to WR_RESP once both handshakes are complete, in either order or in the same cycle.
REQ-017 In WR_RESP, bready SHALL be 1; on bvalid the FSM latches bresp into debug_bresp and moves to DONE.
REQ-018 In RD, arvalid SHALL assert the cycle after accept and hold until arready; the FSM then moves to RD_RESP.
REQ-019 In RD_RESP, rready SHALL be 1; on rvalid the FSM latches rdata[8*lane +: 8] into rbcp_rd and rresp into debug_rresp, then moves to DONE.
REQ-020 In DONE, rbcp_ack SHALL be 1 for exactly one cycle if the latched response is OKAY (2'b00), then the FSM returns to IDLE.
- On SLVERR or DECERR there SHALL be no ack, so the RBCP host times out.
REQ-021 Minimum latency with all readies tied high SHALL be 4 cycles from strobe to ack: accept, addr, resp, DONE.
REQ-022 Strobes arriving while not in IDLE SHALL be ignored, not queued.
REQ-023 Each state other than IDLE and DONE SHALL run a timeout counter, cleared on every state entry.
- When the counter reaches TIMEOUT_CYC, the FSM drops all valids and readies, sets the relevant debug_*resp to 2'b11, and goes to IDLE with no ack.
REQ-024 rbcp_act falling mid-transaction SHALL NOT abort the AXI transaction, which always completes per AXI rules.
- The ack is suppressed if rbcp_act is low while in DONE.
REQ-025 All AXI valid/ready outputs and rbcp_ack SHALL be driven directly from registers.

Reset
REQ-026 Asserting reset SHALL immediately force:
- state IDLE
- all valid and ready outputs 0
- rbcp_ack 0, rbcp_rd 8'h00
- debug_bresp and debug_rresp 2'b00
- awaddr, araddr and wdata 0, wstrb 4'h0
- timeout counter 0
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction; the first strobe after reset release SHALL be processed normally.

Verification
REQ-028 Write: act=1, addr=32'd8, wd=8'hFF, we pulse, readies high -> awaddr=0x8, wdata=0xFFFFFFFF, wstrb=4'b0001, single ack 4 cycles after the strobe, debug_bresp=00.
REQ-029 Read lane: GPIO-like slave returns rdata=32'hFFFFFF00, addr=32'd3, re pulse -> araddr=0x0, rbcp_rd=8'hFF with ack; repeat with addr=0 -> rbcp_rd=8'h00.
REQ-030 Back-pressure: awready delayed 5 cycles and wready granted before it -> both valids each drop after their own handshake, exactly one B handshake, exactly one ack.
REQ-031 Error and timeout:
- bresp=2'b10 -> no ack, debug_bresp=10.
- slave never asserts rvalid -> after 1023 cycles in RD_RESP, rready drops, debug_rresp=11, no ack, next read succeeds.
REQ-032 Collisions: we and re high in the same cycle -> write only, no AR issued; a second re while busy -> ignored, exactly one ack.
REQ-033 Reset during WR_RESP -> all outputs take reset values immediately, no ack; a subsequent write completes normally.

Source files
------------

// File: rtl/rbcp_axil_master.sv
// rbcp_axil_master
//   Bridges the byte-wide SiTCP RBCP register port to single 32-bit
//   AXI4-Lite master transactions (one outstanding access at a time).
//
// Ports
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   rbcp_act           : RBCP session active; requests only accepted while high
//   rbcp_addr/wd       : byte address / write byte
//   rbcp_we/re         : single-cycle write / read strobes
//   rbcp_ack/rd        : single-cycle completion pulse / read byte
//   m_axi_*            : AXI4-Lite master (AW, W, B, AR, R channels)
//   debug_bresp/rresp  : last B / R response code, 2'b11 after a timeout
module rbcp_axil_master #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rbcp_act,
    input  logic [31:0] rbcp_addr,
    input  logic [7:0]  rbcp_wd,
    input  logic        rbcp_we,
    input  logic        rbcp_re,
    output logic        rbcp_ack,
    output logic [7:0]  rbcp_rd,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [1:0]  debug_bresp,
    output logic [1:0]  debug_rresp
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int              CW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]   TO_MAX = CW'(TIMEOUT_CYC);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   awaddr_q, awaddr_d, araddr_q, araddr_d, wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [1:0]    lane_q, lane_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic          arvalid_q, arvalid_d, rready_q, rready_d, ack_q, ack_d;
    logic [7:0]    rd_q, rd_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic          aw_done, w_done, timeout;

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        lane_d    = lane_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        rd_d      = rd_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        aw_done   = 1'b0;
        w_done    = 1'b0;
        timeout   = (cnt_q == TO_MAX);

        case (state_q)
            S_IDLE: begin
                // Write has priority when both strobes arrive together.
                if (rbcp_act && rbcp_we) begin
                    awaddr_d  = {rbcp_addr[31:2], 2'b00};
                    wdata_d   = {4{rbcp_wd}};
                    wstrb_d   = 4'b0001 << rbcp_addr[1:0];
                    lane_d    = rbcp_addr[1:0];
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_WR;
                end else if (rbcp_act && rbcp_re) begin
                    araddr_d  = {rbcp_addr[31:2], 2'b00};
                    lane_d    = rbcp_addr[1:0];
                    arvalid_d = 1'b1;
                    state_d   = S_RD;
                end
            end
            S_WR: begin
                // Both valids are raised on entry, so a cleared valid means
                // that channel has already handshaken.
                aw_done = !awvalid_q || m_axi_awready;
                w_done  = !wvalid_q || m_axi_wready;
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end else if (timeout) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bresp_d   = 2'b11;
                    state_d   = S_IDLE;
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    bresp_d  = m_axi_bresp;
                    ack_d    = (m_axi_bresp == 2'b00) && rbcp_act;
                    state_d  = S_DONE;
                end else if (timeout) begin
                    bready_d = 1'b0;
                    bresp_d  = 2'b11;
                    state_d  = S_IDLE;
                end
            end
            S_RD: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_RESP;
                end else if (timeout) begin
                    arvalid_d = 1'b0;
                    rresp_d   = 2'b11;
                    state_d   = S_IDLE;
                end
            end
            S_RD_RESP: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    rd_d     = m_axi_rdata[8*lane_q +: 8];
                    rresp_d  = m_axi_rresp;
                    ack_d    = (m_axi_rresp == 2'b00) && rbcp_act;
                    state_d  = S_DONE;
                end else if (timeout) begin
                    rready_d = 1'b0;
                    rresp_d  = 2'b11;
                    state_d  = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Timeout counter restarts on every state change.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_WR || state_q == S_WR_RESP ||
                     state_q == S_RD || state_q == S_RD_RESP) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'h0;
            lane_q    <= 2'b00;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            rd_q      <= 8'h00;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            lane_q    <= lane_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            rd_q      <= rd_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
        end
    end

    assign rbcp_ack      = ack_q;
    assign rbcp_rd       = rd_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign debug_bresp   = bresp_q;
    assign debug_rresp   = rresp_q;
endmodule
